// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
//
// Multi-channel LED driver. A shared prescaler produces a one-cycle tick every
// DIV = CLK_HZ/TICK_HZ clocks. Each channel runs independently in one of four
// modes: OFF, ON, BLINK (half-period counted in ticks) or PWM (duty compared
// against a free-running counter shared by all channels).
//
// Ports:
//   clk_25mhz  in   system clock
//   rst_i      in   asynchronous active-high reset
//   cfg_we     in   config write strobe, one cycle per write
//   cfg_ch     in   target channel index (writes to channels >= NUM_LEDS ignored)
//   cfg_mode   in   0=OFF, 1=ON, 2=BLINK, 3=PWM
//   cfg_val    in   BLINK half-period in ticks, or PWM duty in low PWM_W bits
//   led_o      out  registered LED outputs, one per channel
//   tick_o     out  one-cycle pulse per prescaler wrap
// ---------------------------------------------------------------------------
module led_pattern_gen #(
    parameter int NUM_LEDS = 8,
    parameter int CLK_HZ   = 25_000_000,
    parameter int TICK_HZ  = 1_000,
    parameter int VAL_W    = 16,
    parameter int PWM_W    = 8,
    localparam int CH_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk_25mhz,
    input  logic                rst_i,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [VAL_W-1:0]    cfg_val,
    output logic [NUM_LEDS-1:0] led_o,
    output logic                tick_o
);

    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PS_W = $clog2(DIV);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;

    logic [PS_W-1:0]     presc;
    logic [PWM_W-1:0]    pwm_cnt;
    logic [NUM_LEDS-1:0] led_nxt;

    // Prescaler: 0..DIV-1, tick is decoded from the registered count so it
    // falls together with the counter when reset is asserted.
    always_ff @(posedge clk_25mhz or posedge rst_i) begin
        if (rst_i) begin
            presc <= '0;
        end else if (presc == PS_W'(DIV - 1)) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick_o = (presc == PS_W'(DIV - 1));

    // Shared PWM ramp, wraps naturally at 2^PWM_W.
    always_ff @(posedge clk_25mhz or posedge rst_i) begin
        if (rst_i) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        mode_t            mode;
        logic [VAL_W-1:0] val;
        logic [VAL_W-1:0] cnt;
        logic             phase;
        logic             wr_hit;
        logic [VAL_W-1:0] last;

        // Out-of-range channel indices never match any generated channel.
        assign wr_hit = cfg_we && (cfg_ch == CH_W'(i));

        // A half-period of 0 behaves as 1 tick.
        assign last = (val == '0) ? '0 : val - 1'b1;

        // A write wins over a coincident tick: the channel restarts from
        // phase 0 and that tick is not counted.
        always_ff @(posedge clk_25mhz or posedge rst_i) begin
            if (rst_i) begin
                mode  <= MODE_OFF;
                val   <= '0;
                cnt   <= '0;
                phase <= 1'b0;
            end else if (wr_hit) begin
                mode  <= mode_t'(cfg_mode);
                val   <= cfg_val;
                cnt   <= '0;
                phase <= 1'b0;
            end else if (mode != MODE_BLINK) begin
                cnt   <= '0;
                phase <= 1'b0;
            end else if (tick_o) begin
                if (cnt == last) begin
                    cnt   <= '0;
                    phase <= ~phase;
                end else begin
                    cnt   <= cnt + 1'b1;
                end
            end
        end

        assign led_nxt[i] = (mode == MODE_ON) ||
                            ((mode == MODE_BLINK) && phase) ||
                            ((mode == MODE_PWM) && (pwm_cnt < val[PWM_W-1:0]));
    end

    always_ff @(posedge clk_25mhz or posedge rst_i) begin
        if (rst_i) begin
            led_o <= '0;
        end else begin
            led_o <= led_nxt;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_gen
//
// Bench for led_pattern_gen with DIV=10, four channels and a 4-bit PWM ramp.
// A reference model tracks, per channel, the mode, value and number of ticks
// seen in BLINK mode since the last write; the expected LED level is derived
// from those with plain arithmetic. A compare process checks led_o/tick_o
// against the model on every falling edge; directed steps add hand-computed
// expectations. With four channels every cfg_ch encoding is a valid channel,
// so an out-of-range write cannot be expressed on the port.
// ---------------------------------------------------------------------------
module tb_led_pattern_gen;

    localparam int NL  = 4;
    localparam int DIV = 10;
    localparam int VW  = 16;
    localparam int PW  = 4;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we  = 1'b0;
    logic [CW-1:0] ch  = '0;
    logic [1:0]    mode = '0;
    logic [VW-1:0] val = '0;
    logic [NL-1:0] led;
    logic          tick;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    led_pattern_gen #(
        .NUM_LEDS(NL),
        .CLK_HZ  (100),
        .TICK_HZ (10),
        .VAL_W   (VW),
        .PWM_W   (PW)
    ) dut (
        .clk_25mhz(clk),
        .rst_i    (rst),
        .cfg_we   (we),
        .cfg_ch   (ch),
        .cfg_mode (mode),
        .cfg_val  (val),
        .led_o    (led),
        .tick_o   (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_cyc = 0;
    int            m_mode [NL];
    int            m_val  [NL];
    int            m_k    [NL];
    logic [NL-1:0] exp_led  = '0;
    logic          exp_tick = 1'b0;

    function automatic logic blink_level(input int k, input int v);
        int h;
        h = (v == 0) ? 1 : v;
        return ((k / h) % 2) == 1;
    endfunction

    initial begin
        for (int i = 0; i < NL; i++) begin
            m_mode[i] = 0; m_val[i] = 0; m_k[i] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_cyc = 0;
                for (int i = 0; i < NL; i++) begin
                    m_mode[i] = 0; m_val[i] = 0; m_k[i] = 0;
                end
                exp_led  = '0;
                exp_tick = 1'b0;
            end else begin
                bit t;
                int pwm;
                t   = (m_cyc % DIV) == DIV - 1;
                pwm = m_cyc % (1 << PW);
                for (int i = 0; i < NL; i++) begin
                    case (m_mode[i])
                        1:       exp_led[i] = 1'b1;
                        2:       exp_led[i] = blink_level(m_k[i], m_val[i]);
                        3:       exp_led[i] = pwm < (m_val[i] % (1 << PW));
                        default: exp_led[i] = 1'b0;
                    endcase
                end
                for (int i = 0; i < NL; i++) begin
                    if (we && (int'(ch) == i)) begin
                        m_mode[i] = int'(mode);
                        m_val[i]  = int'(val);
                        m_k[i]    = 0;
                    end else if (t && m_mode[i] == 2) begin
                        m_k[i]++;
                    end
                end
                m_cyc++;
                exp_tick = (m_cyc % DIV) == DIV - 1;
            end
        end
    end

    // ---------------- continuous compare ----------------
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("model_led", led, exp_led);
            chk("model_tick", tick, exp_tick);
        end
    end

    // ---------------- helpers ----------------
    task automatic wr(input int c, input int md, input int v);
        ch   = c[CW-1:0];
        mode = md[1:0];
        val  = v[VW-1:0];
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
    endtask

    // Returns one falling edge after the edge that closes the n-th tick cycle.
    task automatic wait_ticks(input int n);
        int seen;
        int budget;
        seen = 0;
        budget = 0;
        while (seen < n && budget < 100 * DIV) begin
            if (tick === 1'b1) seen++;
            @(negedge clk);
            budget++;
        end
        if (seen < n) begin
            total++;
            bad++;
            $display("FAIL wait_ticks: saw %0d ticks, expected %0d", seen, n);
        end
    endtask

    task automatic wait_tick_high();
        int budget;
        budget = 0;
        while (tick !== 1'b1 && budget < 4 * DIV) begin
            @(negedge clk);
            budget++;
        end
        if (tick !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL wait_tick_high: tick_o never rose");
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int hi;
        logic p;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_led", led, 0);
        chk("reset_tick", tick, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Idle: first tick in the 10th cycle after release, then every 10.
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            chk("idle_tick", tick, ((c % DIV) == DIV - 1) ? 1 : 0);
            chk("idle_led", led, 0);
        end

        // ON / OFF with one-cycle write latency.
        wr(1, 1, 0);
        chk("on_latency", led[1], 0);
        @(negedge clk);
        chk("on_visible", led[1], 1);
        chk("on_others", led & 4'b1101, 0);
        wr(2, 0, 0);
        repeat (2) @(negedge clk);
        chk("off_ch2", led, 4'b0010);

        // BLINK half-period 3 on ch0.
        wr(0, 2, 3);
        chk("blink3_first", led[0], 0);
        wait_ticks(3);
        chk("blink3_hold", led[0], 0);
        @(negedge clk);
        chk("blink3_rise", led[0], 1);
        wait_ticks(3);
        chk("blink3_high", led[0], 1);
        @(negedge clk);
        chk("blink3_fall", led[0], 0);

        // BLINK half-period 0 on ch3 toggles every tick.
        wr(3, 2, 0);
        chk("blink0_first", led[3], 0);
        wait_ticks(1);
        chk("blink0_hold", led[3], 0);
        @(negedge clk);
        chk("blink0_rise", led[3], 1);
        wait_ticks(1);
        @(negedge clk);
        chk("blink0_fall", led[3], 0);

        // PWM duty over a 16-cycle window.
        wr(2, 3, 4);
        repeat (2) @(negedge clk);
        hi = 0;
        for (int c = 0; c < 16; c++) begin hi += int'(led[2]); @(negedge clk); end
        chk("pwm_duty4", hi, 4);
        wr(2, 3, 0);
        repeat (2) @(negedge clk);
        hi = 0;
        for (int c = 0; c < 16; c++) begin hi += int'(led[2]); @(negedge clk); end
        chk("pwm_duty0", hi, 0);
        wr(2, 3, 15);
        repeat (2) @(negedge clk);
        hi = 0;
        for (int c = 0; c < 16; c++) begin hi += int'(led[2]); @(negedge clk); end
        chk("pwm_duty15", hi, 15);

        // Write coinciding with a tick.
        wr(1, 2, 1);
        repeat (3) @(negedge clk);
        wait_tick_high();
        wr(0, 2, 2);
        p = led[1];
        @(negedge clk);
        chk("tick_other_toggle", led[1], 1'(~p));
        chk("tick_write_first", led[0], 0);
        wait_ticks(1);
        @(negedge clk);
        chk("tick_write_not_counted", led[0], 0);
        wait_ticks(1);
        chk("tick_write_hold", led[0], 0);
        @(negedge clk);
        chk("tick_write_rise", led[0], 1);

        // Asynchronous reset between edges.
        wr(2, 1, 0);
        repeat (2) @(negedge clk);
        wait_tick_high();
        chk("pre_rst_led", led[2], 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_led", led, 0);
        chk("async_rst_tick", tick, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_rst_all_off", led, 0);

        // Random configuration traffic against the model.
        for (int n = 0; n < 800; n++) begin
            int md;
            int v;
            repeat ($urandom_range(0, 20)) @(negedge clk);
            md = int'($urandom_range(0, 3));
            v  = (md == 2) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 40));
            wr(int'($urandom_range(0, NL - 1)), md, v);
        end
        repeat (100) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
